// File: rtl/note_sequencer_if.sv
// Song-ROM bus between note_sequencer (master) and the song ROM (slave).
// step_data is expected one cycle after step_addr.
interface note_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int SONG_LEN  = 32
);
    logic [$clog2(SONG_LEN)-1:0] step_addr;
    logic [NUM_LANES-1:0]        step_data;

    modport master (output step_addr, input  step_data);
    modport slave  (input  step_addr, output step_data);
endinterface

// File: rtl/note_sequencer.sv
// Song-playback controller: fetches lane patterns, spawns notes at a difficulty tempo,
// pauses/aborts with the game mode. Define NOTE_SEQ_LOOP_EN for endless looping play.
module note_sequencer #(
    parameter int NUM_LANES   = 4,
    parameter int SONG_LEN    = 32,
    parameter int BASE_PERIOD = 16,
    parameter int DRAIN_TICKS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mode,
    input  logic [1:0]            diff_sel,
    input  logic                  tick_en,
    note_sequencer_if.master      rom,
    output logic [NUM_LANES-1:0]  note_spawn,
    output logic                  fin_check,
    output logic                  playing
);
    localparam int ADDR_W = $clog2(SONG_LEN);
    localparam int CNT_W  = $clog2(BASE_PERIOD);
    localparam int DRN_W  = $clog2(DRAIN_TICKS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_TICKS - 1);
    localparam logic [2:0]        MODE_RUN   = 3'd4;
    localparam logic [2:0]        MODE_PAUSE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SPAWN, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t                 state, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]       tick_cnt, cnt_d;
    logic [DRN_W-1:0]       drain_cnt, drn_d;
    logic [1:0]             diff_q, diff_d;
    logic [NUM_LANES-1:0]   spawn_d;
    logic                   fin_d, play_d, run_q;
    logic [CNT_W:0]         period;
    logic [CNT_W-1:0]       period_m1;
    logic                   is_run, is_pause, start;

    assign period    = (CNT_W+1)'(BASE_PERIOD) >> diff_q;
    assign period_m1 = CNT_W'(period - (CNT_W+1)'(1));
    assign is_run    = (mode == MODE_RUN);
    assign is_pause  = (mode == MODE_PAUSE);
    // A run starts only on entry into RUN, so a finished song does not restart.
    assign start     = is_run && !run_q;
    assign rom.step_addr = addr_q;

    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        cnt_d   = tick_cnt;
        drn_d   = drain_cnt;
        diff_d  = diff_q;
        spawn_d = '0;
        fin_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    diff_d  = diff_sel;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_SPAWN, S_WAIT, S_DRAIN: begin
                if (is_pause) begin
                    state_d = state;
                end else if (!is_run) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                    drn_d   = '0;
                end else if (state == S_FETCH) begin
                    state_d = S_SPAWN;
                end else if (state == S_SPAWN) begin
                    spawn_d = rom.step_data;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (state == S_WAIT) begin
                    if (tick_en) begin
                        cnt_d = tick_cnt + CNT_W'(1);
                        if (tick_cnt == period_m1) begin
                            if (addr_q != LAST_ADDR) begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = S_FETCH;
                            end else begin
`ifdef NOTE_SEQ_LOOP_EN
                                addr_d  = '0;
                                diff_d  = (diff_q == 2'd3) ? 2'd3 : diff_q + 2'd1;
                                state_d = S_FETCH;
`else
                                cnt_d   = '0;
                                drn_d   = '0;
                                state_d = S_DRAIN;
`endif
                            end
                        end
                    end
                end else begin
                    if (tick_en) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            drn_d = drain_cnt + DRN_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                fin_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        play_d = (state_d == S_FETCH) || (state_d == S_SPAWN) ||
                 (state_d == S_WAIT)  || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            tick_cnt   <= '0;
            drain_cnt  <= '0;
            diff_q     <= '0;
            note_spawn <= '0;
            fin_check  <= 1'b0;
            playing    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state      <= state_d;
            addr_q     <= addr_d;
            tick_cnt   <= cnt_d;
            drain_cnt  <= drn_d;
            diff_q     <= diff_d;
            note_spawn <= spawn_d;
            fin_check  <= fin_d;
            playing    <= play_d;
            run_q      <= is_run;
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: reset, start latency, tempo, pause, abort,
// song end (default build) or looping play (NOTE_SEQ_LOOP_EN).
module tb_note_sequencer;
    localparam int NL = 4;
    localparam int SL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    mode;
    logic [1:0]    diff_sel;
    logic          tick_en;
    logic [NL-1:0] note_spawn;
    logic          fin_check;
    logic          playing;

    note_sequencer_if #(.NUM_LANES(NL), .SONG_LEN(SL)) rif ();

    note_sequencer #(
        .NUM_LANES   (NL),
        .SONG_LEN    (SL),
        .BASE_PERIOD (16),
        .DRAIN_TICKS (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .diff_sel   (diff_sel),
        .tick_en    (tick_en),
        .rom        (rif),
        .note_spawn (note_spawn),
        .fin_check  (fin_check),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    logic [NL-1:0] rom [SL];
    always @(posedge clk) rif.step_data <= rom[rif.step_addr];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int unsigned cyc_n = 0;
    int unsigned tick_div = 0;
    int unsigned tick_phase = 0;
    logic        edge_tick;
    logic [2:0]  edge_mode;

    // Advance one edge; edge_tick/edge_mode record what that edge sampled.
    task automatic cyc();
        edge_tick = tick_en;
        edge_mode = mode;
        @(posedge clk);
        #1;
        cyc_n++;
        tick_phase++;
        tick_en = (tick_div != 0) && (tick_phase % tick_div == 0);
    endtask

    // Count ticks seen in RUN; the next spawn must appear 2 edges after the period-th.
    task automatic wait_step(input string tag, input int unsigned period, input int unsigned pre,
                             input logic [NL-1:0] exp_data, input logic [4:0] exp_addr);
        int unsigned cnt;
        int unsigned e;
        bit          found;
        cnt = pre;
        e = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2000; i++) begin
            cyc();
            if (edge_tick && edge_mode == 3'd4 && cnt < period) begin
                cnt++;
                if (cnt == period) e = cyc_n;
            end
            if (note_spawn != '0) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(found), 1);
        check({tag, "_lat"}, cyc_n - e, 2);
        check({tag, "_data"}, 32'(note_spawn), 32'(exp_data));
        check({tag, "_addr"}, 32'(rif.step_addr), 32'(exp_addr));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned cnt, extra, hits, start_n, spawns, fins, fin_at, last_sp;
        int unsigned idx, prev;
        bit found;

        for (int unsigned k = 0; k < SL; k++) rom[k] = NL'((k % 15) + 1);
        rom[0] = 4'b0101;
        rst = 1'b1; mode = 3'd1; diff_sel = 2'd0; tick_en = 1'b0;

        cyc(); cyc();
        check("rst_spawn", 32'(note_spawn), 0);
        check("rst_fin", 32'(fin_check), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_addr", 32'(rif.step_addr), 0);
        rst = 1'b0;

        // Start at difficulty 0 with a tick every 4 cycles
        mode = 3'd3; cyc();
        mode = 3'd4; tick_div = 4; tick_phase = 0;
        cyc();
        check("start_playing", 32'(playing), 1);
        check("start_spawn", 32'(note_spawn), 0);
        cyc();
        check("fetch_spawn", 32'(note_spawn), 0);
        cyc();
        check("step0_data", 32'(note_spawn), 32'(4'b0101));
        check("step0_addr", 32'(rif.step_addr), 0);
        diff_sel = 2'd3;
        wait_step("step1", 16, 0, rom[1], 5'd1);

        // Pause mid-WAIT after 5 counted ticks
        cnt = 0; extra = 0;
        for (int unsigned i = 0; i < 200 && cnt < 5; i++) begin
            cyc();
            if (edge_tick && edge_mode == 3'd4) cnt++;
            if (note_spawn != '0) extra++;
        end
        check("pulse_width", extra, 0);
        mode = 3'd5; hits = 0;
        for (int unsigned i = 0; i < 50; i++) begin
            cyc();
            if (note_spawn != '0) hits++;
            if (rif.step_addr != 5'd1) hits++;
            if (!playing) hits++;
        end
        check("pause_frozen", hits, 0);
        mode = 3'd4;
        wait_step("step2", 16, 5, rom[2], 5'd2);

        // Quit at step 10 with a tick in the same cycle
        mode = 3'd1; tick_div = 0; tick_en = 1'b0;
        cyc(); cyc();
        mode = 3'd3; diff_sel = 2'd3; cyc();
        mode = 3'd4; tick_div = 1; tick_en = 1'b1;
        found = 1'b0;
        for (int unsigned i = 0; i < 500; i++) begin
            cyc();
            if (note_spawn != '0 && rif.step_addr == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reach", 32'(found), 1);
        mode = 3'd6;
        cyc();
        check("abort_playing", 32'(playing), 0);
        check("abort_addr", 32'(rif.step_addr), 0);
        check("abort_spawn", 32'(note_spawn), 0);
        check("abort_fin", 32'(fin_check), 0);
        hits = 0;
        mode = 3'd1;
        for (int unsigned i = 0; i < 10; i++) begin
            cyc();
            if (fin_check || note_spawn != '0 || playing) hits++;
        end
        check("abort_quiet", hits, 0);

`ifndef NOTE_SEQ_LOOP_EN
        // Full song at difficulty 3 with continuous ticks: 4 cycles per step
        mode = 3'd3; diff_sel = 2'd3; tick_div = 0; tick_en = 1'b0; cyc();
        mode = 3'd4; tick_div = 1; tick_en = 1'b1;
        cyc();
        start_n = cyc_n;
        spawns = 0; fins = 0; fin_at = 0; last_sp = 0;
        for (int unsigned i = 0; i < 400; i++) begin
            cyc();
            if (note_spawn != '0) begin
                spawns++;
                last_sp = cyc_n;
            end
            if (fin_check) begin
                fins++;
                if (fin_at == 0) begin
                    fin_at = cyc_n;
                    check("fin_playing", 32'(playing), 0);
                end
            end
            if (fin_at != 0 && cyc_n > fin_at + 20) break;
        end
        check("song_fin_time", fin_at - start_n, 153);
        check("song_drain", fin_at - last_sp, 27);
        check("song_spawns", spawns, 32);
        check("song_fin_once", fins, 1);
        check("song_addr_hold", 32'(rif.step_addr), 31);
        check("song_idle", 32'(playing), 0);
`else
        // Looping play: period 4 in the first pass, 2 after the wrap
        for (int unsigned k = 0; k < SL; k++) rom[k] = 4'b1111;
        mode = 3'd3; diff_sel = 2'd2; tick_div = 0; tick_en = 1'b0; cyc();
        mode = 3'd4; tick_div = 1; tick_en = 1'b1;
        idx = 0; prev = 0; fins = 0;
        for (int unsigned i = 0; i < 1000 && idx < 97; i++) begin
            cyc();
            if (fin_check) fins++;
            if (note_spawn != '0) begin
                if (idx == 1) check("loop_gap_first", cyc_n - prev, 6);
                if (idx == 32) begin
                    check("loop_gap_wrap", cyc_n - prev, 6);
                    check("loop_wrap_addr", 32'(rif.step_addr), 0);
                end
                if (idx == 33) check("loop_gap_fast", cyc_n - prev, 4);
                if (idx == 96) check("loop_gap_sat", cyc_n - prev, 4);
                prev = cyc_n;
                idx++;
            end
        end
        check("loop_spawns", idx, 97);
        check("loop_no_fin", fins, 0);
        check("loop_playing", 32'(playing), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
